pulse_generator: RTL and testbench

//  Turns single-cycle trigger pulses, as produced by edge_trigger, back into timed level pulses.

---
 rtl/daq_pkg.sv | 5 +
 rtl/pulse_generator.sv | 82 ++++++++
 tb/tb_pulse_generator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/daq_pkg.sv
// daq_pkg: shared types and defaults for the DAQ timing blocks
package daq_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, HOLDOFF} pgen_state_t;
  localparam int PGEN_CNT_W_DEF = 16;
endpackage

// File: rtl/pulse_generator.sv
// pulse_generator: turns single-cycle triggers into delayed, timed level pulses with holdoff
module pulse_generator
  import daq_pkg::*;
#(
  parameter int CNT_W  = PGEN_CNT_W_DEF,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  delay_cfg,
  input  logic [CNT_W-1:0]  width_cfg,
  input  logic [CNT_W-1:0]  hold_cfg,
  input  logic              retrig_en,
  input  logic              miss_clr,
  output logic              pulse_out,
  output logic              busy,
  output logic [MISS_W-1:0] miss_cnt
);
  pgen_state_t state;
  logic [CNT_W-1:0] cnt, width_q, hold_q;
  logic retrig, miss;
  function automatic logic [CNT_W-1:0] last(input logic [CNT_W-1:0] w);
    return w == '0 ? '0 : w - 1'b1;
  endfunction
  assign retrig = state == ACTIVE && retrig_en && trig_in;
  assign miss   = trig_in && (!enable || (state != IDLE && !retrig));
  // outputs mirror the state of the previous cycle, so the pulse trails acceptance by one edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      width_q   <= '0;
      hold_q    <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pulse_out <= enable && state == ACTIVE;
      busy      <= enable && state != IDLE;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else
        case (state)
          IDLE:
            if (trig_in) begin
              width_q <= width_cfg;
              hold_q  <= hold_cfg;
              state   <= delay_cfg == '0 ? ACTIVE : DELAY;
              cnt     <= delay_cfg == '0 ? last(width_cfg) : delay_cfg - 1'b1;
            end
          DELAY:
            if (cnt == '0) begin
              state <= ACTIVE;
              cnt   <= last(width_q);
            end else
              cnt <= cnt - 1'b1;
          ACTIVE:
            if (retrig)
              cnt <= last(width_q);
            else if (cnt == '0) begin
              state <= hold_q == '0 ? IDLE : HOLDOFF;
              cnt   <= last(hold_q);
            end else
              cnt <= cnt - 1'b1;
          HOLDOFF:
            if (cnt == '0)
              state <= IDLE;
            else
              cnt <= cnt - 1'b1;
          default: state <= IDLE;
        endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      miss_cnt <= '0;
    else if (miss_clr)
      miss_cnt <= '0;
    else if (miss && miss_cnt != '1)
      miss_cnt <= miss_cnt + 1'b1;
endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: scenario tasks with per-cycle expected pulse/busy queues
module tb_pulse_generator;
  localparam int CNT_W  = 16;
  localparam int MISS_W = 2;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              trig_in = 1'b0;
  logic [CNT_W-1:0]  delay_cfg = '0;
  logic [CNT_W-1:0]  width_cfg = '0;
  logic [CNT_W-1:0]  hold_cfg = '0;
  logic              retrig_en = 1'b0;
  logic              miss_clr = 1'b0;
  logic              pulse_out, busy;
  logic [MISS_W-1:0] miss_cnt;
  int checks = 0;
  int errors = 0;
  logic [31:0] tv, pv, bv;
  bit pq[$], bq[$];
  bit ep, eb;
  logic [MISS_W-1:0] mq[$];
  logic [MISS_W-1:0] em;

  pulse_generator #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trig_in(trig_in),
    .delay_cfg(delay_cfg), .width_cfg(width_cfg), .hold_cfg(hold_cfg),
    .retrig_en(retrig_en), .miss_clr(miss_clr),
    .pulse_out(pulse_out), .busy(busy), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic load(input int n);
    pq = {};
    bq = {};
    for (int e = 1; e <= n; e++) begin
      pq.push_back(pv[e]);
      bq.push_back(bv[e]);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset pulse_out: got %b exp 0", pulse_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b exp 0", busy); end
    checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL reset miss_cnt: got %0d exp 0", miss_cnt); end
    reset = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_delay();
    delay_cfg = 3; width_cfg = 4; hold_cfg = 2;
    tv = 32'h2; pv = 32'h1E0; bv = 32'h7FC;
    load(12);
    for (int e = 1; e <= 12; e++) begin
      trig_in = tv[e];
      if (e == 2) begin delay_cfg = 0; width_cfg = 1; hold_cfg = 0; end
      @(negedge clk);
      ep = pq.pop_front(); eb = bq.pop_front();
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL delay pulse e%0d: got %b exp %b", e, pulse_out, ep); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL delay busy e%0d: got %b exp %b", e, busy, eb); end
    end
    trig_in = 1'b0;
  endtask

  task automatic test_min_width();
    delay_cfg = 0; width_cfg = 0; hold_cfg = 0;
    tv = 32'hA; pv = 32'h14; bv = 32'h14;
    load(6);
    for (int e = 1; e <= 6; e++) begin
      trig_in = tv[e];
      @(negedge clk);
      ep = pq.pop_front(); eb = bq.pop_front();
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL minw pulse e%0d: got %b exp %b", e, pulse_out, ep); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL minw busy e%0d: got %b exp %b", e, busy, eb); end
    end
    trig_in = 1'b0;
    checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL minw miss_cnt: got %0d exp 0", miss_cnt); end
  endtask

  task automatic test_back_to_back();
    delay_cfg = 0; width_cfg = 2; hold_cfg = 0;
    tv = 32'h16; pv = 32'h6C; bv = 32'h6C;
    load(8);
    for (int e = 1; e <= 8; e++) begin
      trig_in = tv[e];
      @(negedge clk);
      ep = pq.pop_front(); eb = bq.pop_front();
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL b2b pulse e%0d: got %b exp %b", e, pulse_out, ep); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL b2b busy e%0d: got %b exp %b", e, busy, eb); end
    end
    trig_in = 1'b0;
    checks++; if (miss_cnt !== 2'd1) begin errors++; $display("FAIL b2b miss_cnt: got %0d exp 1", miss_cnt); end
  endtask

  task automatic test_retrigger();
    miss_clr = 1'b1;
    @(negedge clk);
    miss_clr = 1'b0;
    checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL clr miss_cnt: got %0d exp 0", miss_cnt); end
    delay_cfg = 0; width_cfg = 5; hold_cfg = 0; retrig_en = 1'b1;
    tv = 32'hA; pv = 32'h1FC; bv = 32'h1FC;
    load(10);
    for (int e = 1; e <= 10; e++) begin
      trig_in = tv[e];
      @(negedge clk);
      ep = pq.pop_front(); eb = bq.pop_front();
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL retrig pulse e%0d: got %b exp %b", e, pulse_out, ep); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL retrig busy e%0d: got %b exp %b", e, busy, eb); end
    end
    trig_in = 1'b0;
    retrig_en = 1'b0;
    checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL retrig miss_cnt: got %0d exp 0", miss_cnt); end
  endtask

  task automatic test_no_retrigger();
    delay_cfg = 0; width_cfg = 5; hold_cfg = 3;
    tv = 32'h12A; pv = 32'h7C; bv = 32'h3FC;
    load(11);
    for (int e = 1; e <= 11; e++) begin
      trig_in = tv[e];
      @(negedge clk);
      ep = pq.pop_front(); eb = bq.pop_front();
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL noretrig pulse e%0d: got %b exp %b", e, pulse_out, ep); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL noretrig busy e%0d: got %b exp %b", e, busy, eb); end
    end
    trig_in = 1'b0;
    checks++; if (miss_cnt !== 2'd3) begin errors++; $display("FAIL noretrig miss_cnt: got %0d exp 3", miss_cnt); end
  endtask

  task automatic test_miss_saturate();
    miss_clr = 1'b1;
    @(negedge clk);
    miss_clr = 1'b0;
    enable = 1'b0;
    mq = {};
    for (int k = 1; k <= 5; k++) begin
      trig_in = 1'b1;
      mq.push_back(MISS_W'(k > 3 ? 3 : k));
      @(negedge clk);
      em = mq.pop_front();
      checks++; if (miss_cnt !== em) begin errors++; $display("FAIL sat miss_cnt k%0d: got %0d exp %0d", k, miss_cnt, em); end
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL sat pulse k%0d: got %b exp 0", k, pulse_out); end
    end
    miss_clr = 1'b1;
    @(negedge clk);
    checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL clr_prio miss_cnt: got %0d exp 0", miss_cnt); end
    miss_clr = 1'b0;
    trig_in = 1'b0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    delay_cfg = 0; width_cfg = 10; hold_cfg = 0;
    tv = 32'h22; pv = 32'h4C; bv = 32'h4C;
    load(8);
    for (int e = 1; e <= 8; e++) begin
      trig_in = tv[e];
      if (e == 4) enable = 1'b0;
      if (e == 5) begin enable = 1'b1; width_cfg = 1; end
      @(negedge clk);
      ep = pq.pop_front(); eb = bq.pop_front();
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL endrop pulse e%0d: got %b exp %b", e, pulse_out, ep); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL endrop busy e%0d: got %b exp %b", e, busy, eb); end
    end
    trig_in = 1'b0;
  endtask

  task automatic test_reset_active();
    delay_cfg = 0; width_cfg = 10; hold_cfg = 0;
    trig_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    checks++; if (pulse_out !== 1'b1) begin errors++; $display("FAIL rstact pre pulse: got %b exp 1", pulse_out); end
    checks++; if (miss_cnt !== 2'd1) begin errors++; $display("FAIL rstact pre miss_cnt: got %0d exp 1", miss_cnt); end
    #2 reset = 1'b0;
    #1;
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL rstact pulse: got %b exp 0", pulse_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstact busy: got %b exp 0", busy); end
    checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL rstact miss_cnt: got %0d exp 0", miss_cnt); end
    @(negedge clk);
    reset = 1'b1;
    width_cfg = 1;
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    checks++; if (pulse_out !== 1'b1) begin errors++; $display("FAIL rstact idle accept: got %b exp 1", pulse_out); end
    @(negedge clk);
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL rstact idle end: got %b exp 0", pulse_out); end
  endtask

  initial begin
    test_reset();
    test_delay();
    test_min_width();
    test_back_to_back();
    test_retrigger();
    test_no_retrigger();
    test_miss_saturate();
    test_enable_drop();
    test_reset_active();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
